// File: rtl/control_pkg.sv
// Shared decode constants for the control unit: opcodes, R-type functs,
// the ALU operation enumeration and the packed control-word layout.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_LUI = 4'b1001
    } aluCtrl_e;

    typedef struct packed {
        logic     regDst;
        logic     regWrite;
        logic     aluSrc;
        logic     memRead;
        logic     memWrite;
        logic     memtoReg;
        logic     jump;
        logic     jumpReg;
        logic     branch;
        logic     branchNe;
        logic     extOp;
        logic     illegal;
        aluCtrl_e aluCtrl;
    } ctrl_t;

    // Every bit inactive, ALU left on ADD: the safe word for anything undecodable.
    localparam ctrl_t CTRL_DEFAULT = '{
        regDst: 1'b0, regWrite: 1'b0, aluSrc: 1'b0, memRead: 1'b0,
        memWrite: 1'b0, memtoReg: 1'b0, jump: 1'b0, jumpReg: 1'b0,
        branch: 1'b0, branchNe: 1'b0, extOp: 1'b0, illegal: 1'b0,
        aluCtrl: ALU_ADD
    };

endpackage

// File: rtl/control_unit_if.sv
// Instruction-field inputs and decoded control outputs of the control unit.
// master drives the instruction fields, slave is the decoder.
interface control_unit_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       illegal_clr;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       Jump;
    logic       JumpReg;
    logic       Branch;
    logic       BranchNe;
    logic       ExtOp;
    logic       Illegal;
    logic       IllegalSticky;
    logic [3:0] ALUCtrl;

    modport master (
        output op, funct, illegal_clr,
        input  RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Jump,
               JumpReg, Branch, BranchNe, ExtOp, Illegal, IllegalSticky, ALUCtrl
    );

    modport slave (
        input  op, funct, illegal_clr,
        output RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Jump,
               JumpReg, Branch, BranchNe, ExtOp, Illegal, IllegalSticky, ALUCtrl
    );
endinterface

// File: rtl/control_unit_alu_decoder.sv
// R-type funct to ALU operation map; functValid flags the arithmetic/logic functs.
module alu_decoder
    import control_pkg::*;
(
    input  logic [5:0] funct,
    output aluCtrl_e   aluCtrl,
    output logic       functValid
);

    always_comb begin
        aluCtrl    = ALU_ADD;
        functValid = 1'b1;
        case (funct)
            FN_ADD:  aluCtrl = ALU_ADD;
            FN_SUB:  aluCtrl = ALU_SUB;
            FN_AND:  aluCtrl = ALU_AND;
            FN_OR:   aluCtrl = ALU_OR;
            FN_XOR:  aluCtrl = ALU_XOR;
            FN_NOR:  aluCtrl = ALU_NOR;
            FN_SLT:  aluCtrl = ALU_SLT;
            FN_SLL:  aluCtrl = ALU_SLL;
            FN_SRL:  aluCtrl = ALU_SRL;
            default: functValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle instruction decoder. Define CONTROL_ILLEGAL_DET_EN to build the
// Illegal output and the sticky IllegalSticky register; otherwise both read 0.
module control_unit
    import control_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);

    aluCtrl_e rAluCtrl;
    logic     functValid;
    ctrl_t    ctrl;

    alu_decoder uAluDecoder (
        .funct      (bus.funct),
        .aluCtrl    (rAluCtrl),
        .functValid (functValid)
    );

    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (bus.op)
            OP_RTYPE: begin
                // jr is handled here because it carries no ALU operation.
                if (bus.funct == FN_JR) begin
                    ctrl.jumpReg = 1'b1;
                end else if (functValid) begin
                    ctrl.regDst   = 1'b1;
                    ctrl.regWrite = 1'b1;
                    ctrl.aluCtrl  = rAluCtrl;
                end else begin
                    ctrl.illegal  = 1'b1;
                end
            end
            OP_ADDI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.extOp = 1'b1;
                ctrl.aluCtrl  = ALU_ADD;
            end
            OP_SLTI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.extOp = 1'b1;
                ctrl.aluCtrl  = ALU_SLT;
            end
            OP_ANDI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluCtrl = ALU_AND;
            end
            OP_ORI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluCtrl = ALU_OR;
            end
            OP_XORI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluCtrl = ALU_XOR;
            end
            OP_LUI: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluCtrl = ALU_LUI;
            end
            OP_LW: begin
                ctrl.regWrite = 1'b1; ctrl.aluSrc   = 1'b1; ctrl.memRead = 1'b1;
                ctrl.memtoReg = 1'b1; ctrl.extOp    = 1'b1; ctrl.aluCtrl = ALU_ADD;
            end
            OP_SW: begin
                ctrl.aluSrc  = 1'b1; ctrl.memWrite = 1'b1; ctrl.extOp = 1'b1;
                ctrl.aluCtrl = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1; ctrl.extOp = 1'b1; ctrl.aluCtrl = ALU_SUB;
            end
            OP_BNE: begin
                ctrl.branch  = 1'b1; ctrl.branchNe = 1'b1; ctrl.extOp = 1'b1;
                ctrl.aluCtrl = ALU_SUB;
            end
            OP_J:    ctrl.jump    = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign bus.RegDst   = ctrl.regDst;
    assign bus.RegWrite = ctrl.regWrite;
    assign bus.ALUSrc   = ctrl.aluSrc;
    assign bus.MemRead  = ctrl.memRead;
    assign bus.MemWrite = ctrl.memWrite;
    assign bus.MemtoReg = ctrl.memtoReg;
    assign bus.Jump     = ctrl.jump;
    assign bus.JumpReg  = ctrl.jumpReg;
    assign bus.Branch   = ctrl.branch;
    assign bus.BranchNe = ctrl.branchNe;
    assign bus.ExtOp    = ctrl.extOp;
    assign bus.ALUCtrl  = ctrl.aluCtrl;

`ifdef CONTROL_ILLEGAL_DET_EN
    logic illegalStickyReg;

    // A new illegal instruction outranks a clear arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalStickyReg <= 1'b0;
        end else if (ctrl.illegal) begin
            illegalStickyReg <= 1'b1;
        end else if (bus.illegal_clr) begin
            illegalStickyReg <= 1'b0;
        end
    end

    assign bus.Illegal       = ctrl.illegal;
    assign bus.IllegalSticky = illegalStickyReg;
`else
    logic unusedIllegalPath;
    assign unusedIllegalPath = &{1'b0, clk, rst_n, bus.illegal_clr, ctrl.illegal};

    assign bus.Illegal       = 1'b0;
    assign bus.IllegalSticky = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a reference decode table feeds a queue of
// expected control words that each test pops and compares against the DUT.
module tb_control_unit;

`ifdef CONTROL_ILLEGAL_DET_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    logic [15:0] expQ[$];
    logic [15:0] expVec;

    control_unit_if cuIf ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cuIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: RegDst RegWrite ALUSrc MemRead MemWrite MemtoReg Jump JumpReg
    //            Branch BranchNe ExtOp Illegal ALUCtrl[3:0]
    wire [15:0] obsVec = {cuIf.RegDst, cuIf.RegWrite, cuIf.ALUSrc, cuIf.MemRead,
                          cuIf.MemWrite, cuIf.MemtoReg, cuIf.Jump, cuIf.JumpReg,
                          cuIf.Branch, cuIf.BranchNe, cuIf.ExtOp, cuIf.Illegal,
                          cuIf.ALUCtrl};

    function automatic logic [15:0] refModel(input logic [5:0] o, input logic [5:0] f);
        logic [11:0] flags;
        logic [3:0]  alu;
        flags = 12'b0000_0000_0001;
        alu   = 4'b0010;
        case (o)
            6'h00: begin
                flags = 12'b1100_0000_0000;
                case (f)
                    6'h20: alu = 4'b0010;
                    6'h22: alu = 4'b0110;
                    6'h24: alu = 4'b0000;
                    6'h25: alu = 4'b0001;
                    6'h26: alu = 4'b0011;
                    6'h27: alu = 4'b0100;
                    6'h2A: alu = 4'b0111;
                    6'h00: alu = 4'b0101;
                    6'h02: alu = 4'b1000;
                    6'h08: flags = 12'b0000_0001_0000;
                    default: flags = 12'b0000_0000_0001;
                endcase
            end
            6'h08: flags = 12'b0110_0000_0010;
            6'h0A: begin flags = 12'b0110_0000_0010; alu = 4'b0111; end
            6'h0C: begin flags = 12'b0110_0000_0000; alu = 4'b0000; end
            6'h0D: begin flags = 12'b0110_0000_0000; alu = 4'b0001; end
            6'h0E: begin flags = 12'b0110_0000_0000; alu = 4'b0011; end
            6'h0F: begin flags = 12'b0110_0000_0000; alu = 4'b1001; end
            6'h23: flags = 12'b0111_0100_0010;
            6'h2B: flags = 12'b0010_1000_0010;
            6'h04: begin flags = 12'b0000_0000_1010; alu = 4'b0110; end
            6'h05: begin flags = 12'b0000_0000_1110; alu = 4'b0110; end
            6'h02: flags = 12'b0000_0010_0000;
            default: flags = 12'b0000_0000_0001;
        endcase
        flags[0] = flags[0] & ILL_EN;
        return {flags, alu};
    endfunction

    // Apply one instruction away from the clock edge and queue its expected word.
    task automatic drive(input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        cuIf.op    = o;
        cuIf.funct = f;
        expQ.push_back(refModel(o, f));
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cuIf.illegal_clr = 1'b0;
        drive(6'h23, 6'h00);
        expVec = expQ.pop_front();
        testsRun++;
        if (obsVec !== expVec) begin
            testsFailed++;
            $display("FAIL reset_decode got=%h want=%h", obsVec, expVec);
        end else $display("[TB] reset_decode lw ok %h", obsVec);
        testsRun++;
        if (cuIf.IllegalSticky !== 1'b0) begin
            testsFailed++;
            $display("FAIL reset_sticky got=%b want=0", cuIf.IllegalSticky);
        end else $display("[TB] reset_sticky ok");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        logic [5:0] fns[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
        foreach (fns[i]) begin
            drive(6'h00, fns[i]);
            expVec = expQ.pop_front();
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("FAIL rtype funct=%h got=%h want=%h", fns[i], obsVec, expVec);
            end else $display("[TB] rtype funct=%h ok %h", fns[i], obsVec);
        end
    endtask

    task automatic test_itype;
        logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h05, 6'h04, 6'h02, 6'h0D,
                                6'h0F, 6'h08, 6'h0A, 6'h0C, 6'h0E};
        foreach (ops[i]) begin
            drive(ops[i], 6'($urandom));
            expVec = expQ.pop_front();
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("FAIL itype op=%h got=%h want=%h", ops[i], obsVec, expVec);
            end else $display("[TB] itype op=%h ok %h", ops[i], obsVec);
        end
    endtask

    task automatic test_illegal_sticky;
        // Clear any sticky state left by earlier illegal opcodes.
        @(negedge clk);
        cuIf.op = 6'h08; cuIf.illegal_clr = 1'b1;
        @(negedge clk);
        cuIf.illegal_clr = 1'b0;
        testsRun++;
        if (cuIf.IllegalSticky !== 1'b0) begin
            testsFailed++;
            $display("FAIL sticky_cleared got=%b want=0", cuIf.IllegalSticky);
        end else $display("[TB] sticky_cleared ok");

        drive(6'h3F, 6'h00);
        expVec = expQ.pop_front();
        testsRun++;
        if (obsVec !== expVec) begin
            testsFailed++;
            $display("FAIL illegal_op got=%h want=%h", obsVec, expVec);
        end else $display("[TB] illegal_op ok %h", obsVec);
        @(posedge clk); #1;
        testsRun++;
        if (cuIf.IllegalSticky !== ILL_EN) begin
            testsFailed++;
            $display("FAIL sticky_set got=%b want=%b", cuIf.IllegalSticky, ILL_EN);
        end else $display("[TB] sticky_set ok");

        @(negedge clk);
        cuIf.op = 6'h08;
        @(posedge clk); #1;
        testsRun++;
        if (cuIf.IllegalSticky !== ILL_EN) begin
            testsFailed++;
            $display("FAIL sticky_hold got=%b want=%b", cuIf.IllegalSticky, ILL_EN);
        end else $display("[TB] sticky_hold ok");

        @(negedge clk);
        cuIf.illegal_clr = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if (cuIf.IllegalSticky !== 1'b0) begin
            testsFailed++;
            $display("FAIL sticky_clr got=%b want=0", cuIf.IllegalSticky);
        end else $display("[TB] sticky_clr ok");

        @(negedge clk);
        cuIf.op = 6'h3F;
        @(posedge clk); #1;
        testsRun++;
        if (cuIf.IllegalSticky !== ILL_EN) begin
            testsFailed++;
            $display("FAIL sticky_set_wins got=%b want=%b", cuIf.IllegalSticky, ILL_EN);
        end else $display("[TB] sticky_set_wins ok");

        @(negedge clk);
        cuIf.illegal_clr = 1'b0; cuIf.op = 6'h08;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (cuIf.IllegalSticky !== 1'b0) begin
            testsFailed++;
            $display("FAIL sticky_async_rst got=%b want=0", cuIf.IllegalSticky);
        end else $display("[TB] sticky_async_rst ok");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if (cuIf.IllegalSticky !== 1'b0) begin
            testsFailed++;
            $display("FAIL sticky_after_rst got=%b want=0", cuIf.IllegalSticky);
        end else $display("[TB] sticky_after_rst ok");
    endtask

    task automatic test_back_to_back;
        for (int o = 0; o < 64; o++) begin
            drive(6'(o), 6'($urandom));
            expVec = expQ.pop_front();
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("FAIL sweep_op op=%h funct=%h got=%h want=%h",
                         cuIf.op, cuIf.funct, obsVec, expVec);
            end else $display("[TB] sweep_op op=%h ok %h", cuIf.op, obsVec);
        end
        for (int f = 0; f < 64; f++) begin
            drive(6'h00, 6'(f));
            expVec = expQ.pop_front();
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("FAIL sweep_funct funct=%h got=%h want=%h", cuIf.funct, obsVec, expVec);
            end else $display("[TB] sweep_funct funct=%h ok %h", cuIf.funct, obsVec);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cuIf.op     = 6'h00;
        cuIf.funct  = 6'h20;
        cuIf.illegal_clr = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_illegal_sticky();
        test_back_to_back();
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard_leftover got=%0d want=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports as listed; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  clock; used only by the illegal-detect register.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  6  instruction[31:26]; funct  in  6  instruction[5:0].
REQ-005 illegal_clr  in  1  synchronous clear of the sticky illegal flag.
REQ-006 Outputs, each 1 bit:
- RegDst: rd vs rt.
- RegWrite.
- ALUSrc: immediate operand.
- MemRead, MemWrite.
- MemtoReg: load data to the register file.
- Jump: j target.
- JumpReg: jr.
- Branch: conditional branch.
- BranchNe: branch when not equal.
- ExtOp: 1 = sign-extend, 0 = zero-extend.
- Illegal: current instruction undecodable.
- IllegalSticky: registered flag.
REQ-007 ALUCtrl  out  4  ALU operation code.

Function
REQ-008 All outputs except IllegalSticky SHALL be purely combinational from op/funct, settling within the same cycle with zero latency.
REQ-009 ALUCtrl encoding:
- AND=0000, OR=0001, ADD=0010, XOR=0011, NOR=0100
- SLL=0101, SUB=0110, SLT=0111, SRL=1000, LUI=1001
REQ-010 Default for every output bit not listed for an instruction: 0; ALUCtrl default ADD.
REQ-011 op 0x00 (R-type): RegDst=1, RegWrite=1, ALUCtrl by funct:
- 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
- 0x2A SLT, 0x00 SLL, 0x02 SRL
REQ-012 op 0x00 with funct 0x08 (jr): JumpReg=1, RegWrite=0, RegDst=0.
REQ-013 op 0x08 addi: RegWrite, ALUSrc, ExtOp=1, ADD.
REQ-014 op 0x0A slti: RegWrite, ALUSrc, ExtOp=1, SLT.
REQ-015 ops 0x0C andi / 0x0D ori / 0x0E xori: RegWrite, ALUSrc, ExtOp=0, ALUCtrl AND/OR/XOR respectively.
REQ-016 op 0x0F lui: RegWrite, ALUSrc, ExtOp=0, LUI.
REQ-017 op 0x23 lw: RegWrite, ALUSrc, MemRead, MemtoReg, ExtOp=1, ADD.
REQ-018 op 0x2B sw: ALUSrc, MemWrite, ExtOp=1, ADD.
REQ-019 op 0x04 beq: Branch, ExtOp=1, SUB. op 0x05 bne: same plus BranchNe=1.
REQ-020 op 0x02 j: Jump=1.
REQ-021 Any other op, or op 0x00 with an unlisted funct, SHALL drive all outputs to their defaults (no register or memory write) and Illegal=1.
REQ-022 IllegalSticky: set on a rising clk edge while Illegal=1. illegal_clr=1 clears it; when clear and set occur in the same cycle, set wins.

Reset
REQ-023 rst_n low SHALL clear IllegalSticky asynchronously; combinational outputs are unaffected by reset.
REQ-024 Deassertion of rst_n SHALL be honoured at the next clk edge; no other state exists.

Configuration
REQ-025 Macro CONTROL_ILLEGAL_DET_EN defined: Illegal and IllegalSticky behave per REQ-021/022.
REQ-026 Macro not defined: Illegal and IllegalSticky are tied 0, no register is built, and decode is otherwise identical.

Structure
REQ-027 Shared package control_pkg SHALL hold the opcode constants, the funct constants and the ALUCtrl enumeration.
REQ-028 One sub-module alu_decoder (funct -> ALUCtrl, plus a funct-valid flag) SHALL be instantiated; the main decoder SHALL handle op decoding.

Verification
REQ-029 op=0x00, funct=0x20 -> RegDst=1, RegWrite=1, ALUCtrl=0010, Illegal=0; funct=0x27 -> ALUCtrl=0100; funct=0x02 -> 1000.
REQ-030 op=0x23 -> RegWrite, ALUSrc, MemRead, MemtoReg=1, ALUCtrl=0010; op=0x2B -> MemWrite=1, RegWrite=0.
REQ-031 op=0x05 -> Branch=1, BranchNe=1, ALUCtrl=0110; op=0x04 -> BranchNe=0; op=0x02 -> Jump=1, all else 0.
REQ-032 op=0x0D -> ALUCtrl=0001, ExtOp=0; op=0x0F -> ALUCtrl=1001; op=0x08 -> ExtOp=1, ALUCtrl=0010.
REQ-033 op=0x3F for one clk -> Illegal=1, RegWrite=0, MemWrite=0; IllegalSticky=1 after the edge and holding. illegal_clr pulse -> 0. Assert rst_n=0 mid-cycle -> IllegalSticky=0 immediately.
REQ-034 op=0x00, funct=0x08 -> JumpReg=1, RegWrite=0; funct=0x3F -> Illegal=1.
